// File: rtl/secuenciador_rtc_if.sv
// Host-write and bus-engine channels of the RTC refresh sequencer.
// Handshake: bus_start is a one-cycle launch and the engine answers with exactly one bus_done pulse;
// wr_req is a level held with wr_addr/wr_data stable until the one-cycle wr_ack.
interface secuenciador_rtc_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       bus_start;
  logic       bus_write;
  logic [7:0] bus_addr;
  logic [7:0] bus_dato_out;
  logic       bus_done;
  logic [7:0] bus_dato_in;

  modport master (
    input  wr_req, wr_addr, wr_data, bus_done, bus_dato_in,
    output wr_ack, bus_start, bus_write, bus_addr, bus_dato_out
  );

  modport slave (
    output wr_req, wr_addr, wr_data, bus_done, bus_dato_in,
    input  wr_ack, bus_start, bus_write, bus_addr, bus_dato_out
  );
endinterface

// File: rtl/secuenciador_rtc.sv
// RTC refresh sequencer: arbitrates host writes against refresh bursts (command write + 9 reads)
// and strobes one register-bank load per byte read, with a per-transaction timeout.
module secuenciador_rtc #(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] CMD_ADDR    = 8'hF0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_refresh,
    secuenciador_rtc_if.master        bif,
    output logic [7:0]                dato_leido,
    output logic [8:0]                hold,
    output logic                      burst_done,
    output logic                      err_timeout,
    output logic                      busy,
    output logic [2:0]                state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, HOST_WR, CMD, RD, LATCH} state_t;

    state_t        state, state_n;
    logic [3:0]    rd_idx, rd_idx_n, lat_idx;
    logic [TW-1:0] timer;
    logic          pending, outstanding;
    logic          launch, l_write;
    logic [7:0]    l_addr, l_data;
    logic          take_read, set_ack, set_bdone, set_err, grant_ref;
    logic          waiting, timed_out;

    function automatic logic [7:0] addr_of(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            4'd8:    return 8'h43;
            default: return 8'h21;
        endcase
    endfunction

    // The next read is launched during LATCH, so LATCH also waits on the bus while a read is in flight.
    always_comb begin
        state_n   = state;
        rd_idx_n  = rd_idx;
        launch    = 1'b0;
        l_write   = 1'b0;
        l_addr    = 8'h00;
        l_data    = 8'h00;
        take_read = 1'b0;
        set_ack   = 1'b0;
        set_bdone = 1'b0;
        set_err   = 1'b0;
        grant_ref = 1'b0;
        waiting   = (state == HOST_WR) || (state == CMD) || (state == RD) ||
                    ((state == LATCH) && outstanding);
        timed_out = waiting && !bif.bus_done && (timer == TW'(TIMEOUT_CYC - 1));

        case (state)
            IDLE: begin
                // wr_ack still high means the just-finished request has not been dropped yet.
                if (bif.wr_req && !bif.wr_ack) begin
                    state_n = HOST_WR;
                    launch  = 1'b1;
                    l_write = 1'b1;
                    l_addr  = bif.wr_addr;
                    l_data  = bif.wr_data;
                end else if (pending) begin
                    state_n   = CMD;
                    launch    = 1'b1;
                    l_write   = 1'b1;
                    l_addr    = CMD_ADDR;
                    grant_ref = 1'b1;
                end
            end
            HOST_WR: begin
                if (bif.bus_done) begin
                    set_ack = 1'b1;
                    state_n = IDLE;
                end
            end
            CMD: begin
                if (bif.bus_done) begin
                    state_n  = RD;
                    rd_idx_n = 4'd0;
                    launch   = 1'b1;
                    l_addr   = addr_of(4'd0);
                end
            end
            RD, LATCH: begin
                if ((state == LATCH) && !outstanding) begin
                    set_bdone = 1'b1;
                    state_n   = IDLE;
                end else if (bif.bus_done) begin
                    take_read = 1'b1;
                    state_n   = LATCH;
                    if (rd_idx != 4'd8) begin
                        rd_idx_n = 4'(rd_idx + 4'd1);
                        launch   = 1'b1;
                        l_addr   = addr_of(4'(rd_idx + 4'd1));
                    end
                end else if (state == LATCH) begin
                    state_n = RD;
                end
            end
            default: state_n = IDLE;
        endcase

        if (timed_out) begin
            state_n = IDLE;
            set_err = 1'b1;
            launch  = 1'b0;
        end
        if (state_n == IDLE) rd_idx_n = 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rd_idx           <= 4'd0;
            lat_idx          <= 4'd0;
            timer            <= '0;
            pending          <= 1'b0;
            outstanding      <= 1'b0;
            dato_leido       <= 8'h00;
            burst_done       <= 1'b0;
            err_timeout      <= 1'b0;
            bif.wr_ack       <= 1'b0;
            bif.bus_start    <= 1'b0;
            bif.bus_write    <= 1'b0;
            bif.bus_addr     <= 8'h00;
            bif.bus_dato_out <= 8'h00;
        end else begin
            state         <= state_n;
            rd_idx        <= rd_idx_n;
            pending       <= (pending && !grant_ref) || tick_refresh;
            bif.bus_start <= launch;
            if (launch) begin
                bif.bus_write    <= l_write;
                bif.bus_addr     <= l_addr;
                bif.bus_dato_out <= l_data;
            end
            if (launch)       timer <= '0;
            else if (waiting) timer <= timer + 1'b1;
            if (launch)                                   outstanding <= 1'b1;
            else if (bif.bus_done || (state_n == IDLE))   outstanding <= 1'b0;
            if (take_read) begin
                dato_leido <= bif.bus_dato_in;
                lat_idx    <= rd_idx;
            end
            bif.wr_ack  <= set_ack;
            burst_done  <= set_bdone;
            err_timeout <= set_err;
        end
    end

    always_comb begin
        hold = 9'd0;
        if (state == LATCH) hold = 9'(1) << lat_idx;
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: doc/secuenciador_rtc.md
SECUENCIADOR_RTC -- requirements
Module: secuenciador_rtc

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, meaning max cycles waited for bus_done per transaction.
REQ-002 SHALL have parameter CMD_ADDR, default 8'hF0, meaning RTC transfer-command register address written before each read burst.
REQ-003 SHALL have clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have tick_refresh  input  1  one-cycle pulse requesting a refresh burst.
REQ-006 SHALL have wr_req  input  1  host write request, level, held until wr_ack.
REQ-007 SHALL have wr_addr, wr_data  input  8 each  host write address and data, stable while wr_req=1.
REQ-008 SHALL have wr_ack  output  1  one-cycle pulse when the host write completes.
REQ-009 SHALL have bus_start  output  1  one-cycle pulse launching a bus-engine transaction.
REQ-010 SHALL have bus_write  output  1  1 = write, 0 = read; bus_addr, bus_dato_out  output  8 each.
REQ-011 SHALL have bus_done  input  1  transaction-complete pulse from bus engine; bus_dato_in  input  8  read data.
REQ-012 SHALL have dato_leido  output  8  last read byte; hold  output  9  one-hot register-bank load strobes.
REQ-013 SHALL have burst_done, err_timeout  output  1 each  one-cycle pulses; busy  output  1  high when not IDLE.

Function
REQ-014 SHALL implement states IDLE, HOST_WR, CMD, RD, LATCH; RD/CMD/HOST_WR each wait for bus_done.
REQ-015 SHALL read, in order, index 0..8 = addresses 21h,22h,23h,24h,25h,26h,41h,42h,43h (seg, min, hora, dia, mes, jahr, seg_timer, min_timer, hora_timer).
REQ-016 SHALL latch a pending-refresh flag on tick_refresh in any state; multiple ticks before service collapse to one.
REQ-017 SHALL, in IDLE, give wr_req priority over pending refresh; arbitration only in IDLE, never mid-burst.
REQ-018 SHALL, on host grant, pulse bus_start the cycle after grant with bus_write=1, bus_addr=wr_addr, bus_dato_out=wr_data.
REQ-019 SHALL, on refresh grant, clear pending, issue write CMD_ADDR/00h, then the 9 reads, each bus_start one cycle after the previous bus_done.
REQ-020 SHALL hold bus_addr, bus_write, bus_dato_out stable from bus_start until bus_done.
REQ-021 SHALL, on bus_done of read index i, register dato_leido <= bus_dato_in, then pulse hold[i] for exactly one cycle (LATCH) with dato_leido valid.
REQ-022 SHALL pulse burst_done in the cycle after hold[8] and return to IDLE.
REQ-023 SHALL pulse wr_ack the cycle after bus_done of a host write and return to IDLE.
REQ-024 SHALL count cycles in every wait state; reaching TIMEOUT_CYC without bus_done pulses err_timeout, aborts the burst/write (no wr_ack, no further hold), returns to IDLE.
REQ-025 SHALL ignore bus_done while IDLE.
REQ-026 SHALL leave hold all-zero except in LATCH; never more than one hold bit set.

Reset
REQ-027 SHALL on reset, any time including mid-transaction, force IDLE, clear pending, index and timeout counter, and drive all outputs to 0 (dato_leido=00h, hold=0).
REQ-028 SHALL resume normal arbitration on the first clock after reset deasserts.

Verification
REQ-029 Single tick, engine done 3 cycles after each start -> 10 bus_start (F0h write, then 21h..43h reads), hold[0..8] in order, burst_done once.
REQ-030 Read data 59h at 21h -> dato_leido=59h while hold[0]=1.
REQ-031 tick_refresh and wr_req (addr 22h, data 30h) same cycle in IDLE -> write 22h/30h first, wr_ack, then refresh burst.
REQ-032 Three ticks during a burst -> exactly one extra burst afterward.
REQ-033 bus_done withheld on read 24h -> err_timeout after 1024 cycles, hold[3..8] never asserted, busy=0.
REQ-034 reset during read 23h wait -> all outputs 0, IDLE; next tick starts a full burst from F0h.
